// File: rtl/hero_mbox_multi.sv
// hero_mbox_multi: multi-channel bidirectional host/device mailbox.
// Each channel has an H2D FIFO (host pushes, device pops) and a D2H FIFO (device pushes, host pops).
// Both sides get the same per-channel register window, plus a per-channel threshold interrupt.
module hero_mbox_multi #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned Depth       = 8,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 host_req_i,
  input  logic                 host_we_i,
  input  logic [AddrWidth-1:0] host_addr_i,
  input  logic [DataWidth-1:0] host_wdata_i,
  output logic                 host_gnt_o,
  output logic                 host_rvalid_o,
  output logic [DataWidth-1:0] host_rdata_o,
  output logic                 host_err_o,
  output logic                 host_irq_o,
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  output logic                 dev_gnt_o,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  output logic                 dev_err_o,
  output logic                 dev_irq_o
);

  localparam int unsigned CntW = 8;
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned ChW  = AddrWidth - 4;
  localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  // FIFO storage and bookkeeping
  logic [DataWidth-1:0] h2d_mem [NumChannels][Depth];
  logic [DataWidth-1:0] d2h_mem [NumChannels][Depth];
  logic [PtrW-1:0]      h2d_wp  [NumChannels];
  logic [PtrW-1:0]      h2d_rp  [NumChannels];
  logic [PtrW-1:0]      d2h_wp  [NumChannels];
  logic [PtrW-1:0]      d2h_rp  [NumChannels];
  logic [CntW-1:0]      h2d_cnt [NumChannels];
  logic [CntW-1:0]      d2h_cnt [NumChannels];

  // Interrupt configuration per side and channel
  logic            h_en  [NumChannels];
  logic [7:0]      h_thr [NumChannels];
  logic            d_en  [NumChannels];
  logic [7:0]      d_thr [NumChannels];

  // Address decode per side
  logic [ChW-1:0]  h_ch, d_ch;
  logic [1:0]      h_sel, d_sel;
  logic            h_ok, d_ok;
  logic [IdxW-1:0] h_idx, d_idx;

  assign h_ch  = host_addr_i[AddrWidth-1:4];
  assign d_ch  = dev_addr_i[AddrWidth-1:4];
  assign h_sel = host_addr_i[3:2];
  assign d_sel = dev_addr_i[3:2];
  assign h_ok  = (host_addr_i[1:0] == 2'b00) && (32'(h_ch) < NumChannels);
  assign d_ok  = (dev_addr_i[1:0] == 2'b00) && (32'(d_ch) < NumChannels);
  assign h_idx = h_ok ? IdxW'(h_ch) : '0;
  assign d_idx = d_ok ? IdxW'(d_ch) : '0;

  assign host_gnt_o = host_req_i;
  assign dev_gnt_o  = dev_req_i;

  // Legal FIFO operations, full/empty judged on pre-edge counts
  logic h_push, h_pop, d_push, d_pop, h_cfg_wr, d_cfg_wr;

  assign h_push   = host_req_i && host_we_i && h_ok && (h_sel == 2'd0) &&
                    (h2d_cnt[h_idx] != CntW'(Depth));
  assign h_pop    = host_req_i && !host_we_i && h_ok && (h_sel == 2'd1) &&
                    (d2h_cnt[h_idx] != '0);
  assign d_push   = dev_req_i && dev_we_i && d_ok && (d_sel == 2'd0) &&
                    (d2h_cnt[d_idx] != CntW'(Depth));
  assign d_pop    = dev_req_i && !dev_we_i && d_ok && (d_sel == 2'd1) &&
                    (h2d_cnt[d_idx] != '0);
  assign h_cfg_wr = host_req_i && host_we_i && h_ok && (h_sel == 2'd3);
  assign d_cfg_wr = dev_req_i && dev_we_i && d_ok && (d_sel == 2'd3);

  logic [NumChannels-1:0] h2d_push, h2d_pop, d2h_push, d2h_pop;

  // Steer the single access per side onto its channel
  always_comb begin
    h2d_push = '0;
    h2d_pop  = '0;
    d2h_push = '0;
    d2h_pop  = '0;
    h2d_push[h_idx] = h_push;
    h2d_pop[d_idx]  = d_pop;
    d2h_push[d_idx] = d_push;
    d2h_pop[h_idx]  = h_pop;
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [DataWidth-1:0] status_word(input logic [CntW-1:0] in_cnt,
                                                       input logic [CntW-1:0] out_cnt);
    return DataWidth'({8'd0, out_cnt, in_cnt, 4'd0,
                       (out_cnt == CntW'(Depth)), (out_cnt == '0),
                       (in_cnt == CntW'(Depth)), (in_cnt == '0)});
  endfunction

  // Response for one side: {err, rdata}
  function automatic logic [DataWidth:0] respond(
    input logic                 req,
    input logic                 we,
    input logic                 ok,
    input logic [1:0]           rsel,
    input logic                 push,
    input logic                 pop,
    input logic [DataWidth-1:0] head,
    input logic [CntW-1:0]      in_cnt,
    input logic [CntW-1:0]      out_cnt,
    input logic                 en,
    input logic [7:0]           thr
  );
    logic [DataWidth-1:0] rdata;
    logic                 err;
    rdata = '0;
    err   = 1'b0;
    if (req) begin
      if (!ok) begin
        err = 1'b1;
      end else begin
        case (rsel)
          2'd0:    err = !push;
          2'd1:    if (pop) rdata = head; else err = 1'b1;
          2'd2:    if (we) err = 1'b1; else rdata = status_word(in_cnt, out_cnt);
          default: if (!we) rdata = DataWidth'({16'd0, thr, 7'd0, en});
        endcase
      end
    end
    return {err, rdata};
  endfunction

  logic [DataWidth:0] h_resp, d_resp;
  logic               h_irq_c, d_irq_c;

  assign h_resp = respond(host_req_i, host_we_i, h_ok, h_sel, h_push, h_pop,
                          d2h_mem[h_idx][d2h_rp[h_idx]], d2h_cnt[h_idx], h2d_cnt[h_idx],
                          h_en[h_idx], h_thr[h_idx]);
  assign d_resp = respond(dev_req_i, dev_we_i, d_ok, d_sel, d_push, d_pop,
                          h2d_mem[d_idx][h2d_rp[d_idx]], h2d_cnt[d_idx], d2h_cnt[d_idx],
                          d_en[d_idx], d_thr[d_idx]);

  // Interrupt condition from each side's inbound fill level
  always_comb begin
    h_irq_c = 1'b0;
    d_irq_c = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (h_en[c] && (h_thr[c] != '0) && (d2h_cnt[c] >= h_thr[c])) h_irq_c = 1'b1;
      if (d_en[c] && (d_thr[c] != '0) && (h2d_cnt[c] >= d_thr[c])) d_irq_c = 1'b1;
    end
  end

  // FIFO data storage (contents are don't-care while the count says empty)
  always_ff @(posedge clk_i) begin
    if (h_push) h2d_mem[h_idx][h2d_wp[h_idx]] <= host_wdata_i;
    if (d_push) d2h_mem[d_idx][d2h_wp[d_idx]] <= dev_wdata_i;
  end

  // FIFO pointers, fill counts and interrupt configuration
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChannels; c++) begin
        h2d_wp[c]  <= '0;
        h2d_rp[c]  <= '0;
        d2h_wp[c]  <= '0;
        d2h_rp[c]  <= '0;
        h2d_cnt[c] <= '0;
        d2h_cnt[c] <= '0;
        h_en[c]    <= 1'b0;
        h_thr[c]   <= '0;
        d_en[c]    <= 1'b0;
        d_thr[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (h2d_push[c]) h2d_wp[c] <= ptr_inc(h2d_wp[c]);
        if (h2d_pop[c])  h2d_rp[c] <= ptr_inc(h2d_rp[c]);
        if (d2h_push[c]) d2h_wp[c] <= ptr_inc(d2h_wp[c]);
        if (d2h_pop[c])  d2h_rp[c] <= ptr_inc(d2h_rp[c]);
        h2d_cnt[c] <= h2d_cnt[c] + CntW'(h2d_push[c]) - CntW'(h2d_pop[c]);
        d2h_cnt[c] <= d2h_cnt[c] + CntW'(d2h_push[c]) - CntW'(d2h_pop[c]);
        if (h_cfg_wr && (h_idx == IdxW'(c))) begin
          h_en[c]  <= host_wdata_i[0];
          h_thr[c] <= host_wdata_i[15:8];
        end
        if (d_cfg_wr && (d_idx == IdxW'(c))) begin
          d_en[c]  <= dev_wdata_i[0];
          d_thr[c] <= dev_wdata_i[15:8];
        end
      end
    end
  end

  // Registered responses and interrupts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
      host_err_o    <= 1'b0;
      host_irq_o    <= 1'b0;
      dev_rvalid_o  <= 1'b0;
      dev_rdata_o   <= '0;
      dev_err_o     <= 1'b0;
      dev_irq_o     <= 1'b0;
    end else begin
      host_rvalid_o <= host_req_i;
      host_rdata_o  <= h_resp[DataWidth-1:0];
      host_err_o    <= h_resp[DataWidth];
      host_irq_o    <= h_irq_c;
      dev_rvalid_o  <= dev_req_i;
      dev_rdata_o   <= d_resp[DataWidth-1:0];
      dev_err_o     <= d_resp[DataWidth];
      dev_irq_o     <= d_irq_c;
    end
  end

endmodule

// File: tb/tb_hero_mbox_multi.sv
// Self-checking bench for hero_mbox_multi: constant vector table, directed corner
// sequences and a randomized run against a queue-based mailbox model.
module tb_hero_mbox_multi;

  localparam int NCH = 4;
  localparam int DEP = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        host_req_i = 1'b0, host_we_i = 1'b0;
  logic [11:0] host_addr_i = '0;
  logic [31:0] host_wdata_i = '0;
  logic        host_gnt_o, host_rvalid_o, host_err_o, host_irq_o;
  logic [31:0] host_rdata_o;
  logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
  logic [11:0] dev_addr_i = '0;
  logic [31:0] dev_wdata_i = '0;
  logic        dev_gnt_o, dev_rvalid_o, dev_err_o, dev_irq_o;
  logic [31:0] dev_rdata_o;

  hero_mbox_multi #(.NumChannels(NCH), .Depth(DEP), .DataWidth(32), .AddrWidth(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o), .host_irq_o(host_irq_o),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
    .dev_wdata_i(dev_wdata_i), .dev_gnt_o(dev_gnt_o), .dev_rvalid_o(dev_rvalid_o),
    .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o), .dev_irq_o(dev_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per FIFO plus interrupt config
  typedef logic [31:0] word_q_t[$];
  word_q_t    q_h2d [NCH];
  word_q_t    q_d2h [NCH];
  logic       m_h_en [NCH], m_d_en [NCH];
  logic [7:0] m_h_thr [NCH], m_d_thr [NCH];

  // Captured responses of the last step
  logic [31:0] h_rd, d_rd;
  logic        h_er, d_er, h_iq, d_iq;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) begin
      q_h2d[c].delete();
      q_d2h[c].delete();
      m_h_en[c] = 1'b0; m_h_thr[c] = '0;
      m_d_en[c] = 1'b0; m_d_thr[c] = '0;
    end
  endfunction

  function automatic logic model_irq(input bit is_host);
    for (int c = 0; c < NCH; c++) begin
      int n;
      n = is_host ? q_d2h[c].size() : q_h2d[c].size();
      if (is_host && m_h_en[c] && m_h_thr[c] != 0 && n >= int'(m_h_thr[c])) return 1'b1;
      if (!is_host && m_d_en[c] && m_d_thr[c] != 0 && n >= int'(m_d_thr[c])) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected response from pre-edge model state; act: 0 none, 1 push, 2 pop, 3 cfg write
  task automatic model_eval(input bit is_host, input logic we, input logic [11:0] addr,
                            output logic [31:0] rd, output logic err, output int act);
    int ch, rg, in_n, out_n;
    ch = int'(addr[11:4]);
    rg = int'(addr[3:2]);
    rd = '0; err = 1'b0; act = 0;
    if (addr[1:0] != 2'b00 || ch >= NCH) begin
      err = 1'b1;
    end else begin
      in_n  = is_host ? q_d2h[ch].size() : q_h2d[ch].size();
      out_n = is_host ? q_h2d[ch].size() : q_d2h[ch].size();
      case (rg)
        0: if (!we || out_n == DEP) err = 1'b1; else act = 1;
        1: if (we || in_n == 0) err = 1'b1;
           else begin rd = is_host ? q_d2h[ch][0] : q_h2d[ch][0]; act = 2; end
        2: if (we) err = 1'b1;
           else rd = out_n * 65536 + in_n * 256 + (out_n == DEP ? 8 : 0) +
                     (out_n == 0 ? 4 : 0) + (in_n == DEP ? 2 : 0) + (in_n == 0 ? 1 : 0);
        default: if (we) act = 3;
           else rd = is_host ? m_h_thr[ch] * 256 + m_h_en[ch] : m_d_thr[ch] * 256 + m_d_en[ch];
      endcase
    end
  endtask

  task automatic model_apply(input bit is_host, input logic [11:0] addr,
                             input logic [31:0] wd, input int act);
    int ch;
    ch = int'(addr[11:4]);
    case (act)
      1: if (is_host) q_h2d[ch].push_back(wd); else q_d2h[ch].push_back(wd);
      2: if (is_host) void'(q_d2h[ch].pop_front()); else void'(q_h2d[ch].pop_front());
      3: if (is_host) begin m_h_en[ch] = wd[0]; m_h_thr[ch] = wd[15:8]; end
         else begin m_d_en[ch] = wd[0]; m_d_thr[ch] = wd[15:8]; end
      default: ;
    endcase
  endtask

  // One clock with optional concurrent host and device accesses, checked against the model
  task automatic run(input logic hr, input logic hw, input logic [11:0] ha, input logic [31:0] hd,
                     input logic dr, input logic dw, input logic [11:0] da, input logic [31:0] dd);
    logic [31:0] ehr, edr;
    logic        ehe, ede, ehi, edi;
    int          hact, dact;
    ehi = model_irq(1'b1);
    edi = model_irq(1'b0);
    ehr = '0; ehe = 1'b0; hact = 0;
    edr = '0; ede = 1'b0; dact = 0;
    if (hr) model_eval(1'b1, hw, ha, ehr, ehe, hact);
    if (dr) model_eval(1'b0, dw, da, edr, ede, dact);
    host_req_i = hr; host_we_i = hw; host_addr_i = ha; host_wdata_i = hd;
    dev_req_i  = dr; dev_we_i  = dw; dev_addr_i  = da; dev_wdata_i  = dd;
    #1;
    chk("host_gnt", 32'(host_gnt_o), 32'(hr));
    chk("dev_gnt", 32'(dev_gnt_o), 32'(dr));
    @(posedge clk_i); #1;
    h_rd = host_rdata_o; h_er = host_err_o; h_iq = host_irq_o;
    d_rd = dev_rdata_o;  d_er = dev_err_o;  d_iq = dev_irq_o;
    chk("host_rvalid", 32'(host_rvalid_o), 32'(hr));
    chk("host_rdata", h_rd, ehr);
    chk("host_err", 32'(h_er), 32'(ehe));
    chk("host_irq", 32'(h_iq), 32'(ehi));
    chk("dev_rvalid", 32'(dev_rvalid_o), 32'(dr));
    chk("dev_rdata", d_rd, edr);
    chk("dev_err", 32'(d_er), 32'(ede));
    chk("dev_irq", 32'(d_iq), 32'(edi));
    model_apply(1'b1, ha, hd, hact);
    model_apply(1'b0, da, dd, dact);
    host_req_i = 1'b0; host_we_i = 1'b0;
    dev_req_i  = 1'b0; dev_we_i  = 1'b0;
  endtask

  task automatic hst(input logic we, input logic [11:0] a, input logic [31:0] d);
    run(1'b1, we, a, d, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic dvc(input logic we, input logic [11:0] a, input logic [31:0] d);
    run(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, we, a, d);
  endtask

  task automatic idle();
    run(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 12'h000; host_wdata_i = 32'hDEAD;
    @(posedge clk_i); #1;
    chk("rst_host_rvalid", 32'(host_rvalid_o), 32'h0);
    chk("rst_host_rdata", host_rdata_o, 32'h0);
    chk("rst_host_err", 32'(host_err_o), 32'h0);
    chk("rst_host_irq", 32'(host_irq_o), 32'h0);
    chk("rst_dev_rvalid", 32'(dev_rvalid_o), 32'h0);
    chk("rst_dev_irq", 32'(dev_irq_o), 32'h0);
    model_clear();
    host_req_i = 1'b0; host_we_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic rand_op(output logic r, output logic w, output logic [11:0] a,
                         output logic [31:0] d);
    int ch, rg, k;
    r  = ($urandom_range(0, 9) < 8);
    ch = ($urandom_range(0, 19) == 0) ? 4 : int'($urandom_range(0, 1));
    k  = int'($urandom_range(0, 9));
    rg = (k < 4) ? 0 : (k < 8) ? 1 : (k == 8) ? 2 : 3;
    w  = (rg == 0) ? 1'b1 : (rg == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
    if ($urandom_range(0, 15) == 0) w = ~w;
    a = {ch[7:0], rg[1:0], 2'b00};
    if ($urandom_range(0, 31) == 0) a[1:0] = 2'($urandom_range(1, 3));
    d = $urandom;
    if (rg == 3) d[15:8] = 8'($urandom_range(0, 9));
  endtask

  typedef struct {
    logic        is_host;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic        hr, hw, dr, dw;
    logic [11:0] ha, da;
    logic [31:0] hd, dd;

    tbl[0]  = '{1'b1, 1'b1, 12'h000, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 12'h004, 32'h0,         32'hA5A5_0001, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 12'h008, 32'h0,         32'h0000_0005, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 12'h010, 32'h0000_0011, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 12'h000, 32'h0,         32'h0000_0000, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 12'h008, 32'h1234,      32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 12'h002, 32'h0,         32'h0000_0000, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 12'h042, 32'h77,        32'h0000_0000, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 12'h040, 32'h77,        32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 12'h048, 32'h0,         32'h0000_0000, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 12'h00C, 32'hFFFF_FF01, 32'h0000_0000, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 12'h00C, 32'h0,         32'h0000_FF01, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 12'h004, 32'h55,        32'h0000_0000, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 12'h018, 32'h0,         32'h0000_0104, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 12'h00C, 32'h0,         32'h0000_FF01, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 12'h00C, 32'h0,         32'h0000_0000, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 12'h014, 32'h0,         32'h0000_0011, 1'b0};

    do_reset();

    // Basic transfer and illegal-access table
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].is_host) begin
        hst(tbl[i].we, tbl[i].addr, tbl[i].wdata);
        chk($sformatf("vec%0d_rdata", i), h_rd, tbl[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), 32'(h_er), 32'(tbl[i].exp_err));
      end else begin
        dvc(tbl[i].we, tbl[i].addr, tbl[i].wdata);
        chk($sformatf("vec%0d_rdata", i), d_rd, tbl[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), 32'(d_er), 32'(tbl[i].exp_err));
      end
    end

    // Overflow and underflow on channel 2
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      hst(1'b1, 12'h020, 32'(i));
      chk($sformatf("ovf_push%0d_err", i), 32'(h_er), (i == 9) ? 32'h1 : 32'h0);
    end
    dvc(1'b0, 12'h028, 32'h0);
    chk("full_status", d_rd, 32'h0000_0806);
    for (int i = 1; i <= 9; i++) begin
      dvc(1'b0, 12'h024, 32'h0);
      chk($sformatf("pop%0d_rdata", i), d_rd, (i == 9) ? 32'h0 : 32'(i));
      chk($sformatf("pop%0d_err", i), 32'(d_er), (i == 9) ? 32'h1 : 32'h0);
    end

    // Threshold interrupt on device side, channel 1
    dvc(1'b1, 12'h01C, 32'h0000_0301);
    for (int i = 0; i < 3; i++) hst(1'b1, 12'h010, 32'(32'hB0 + i));
    chk("irq_after_3rd_push", 32'(d_iq), 32'h0);
    idle();
    chk("irq_rise", 32'(d_iq), 32'h1);
    chk("host_irq_quiet", 32'(h_iq), 32'h0);
    dvc(1'b0, 12'h014, 32'h0);
    chk("irq_pop_rdata", d_rd, 32'h0000_00B0);
    chk("irq_still_high", 32'(d_iq), 32'h1);
    idle();
    chk("irq_fall", 32'(d_iq), 32'h0);

    // Simultaneous push and pop on full and on partially filled FIFO
    do_reset();
    for (int i = 0; i < 8; i++) hst(1'b1, 12'h030, 32'(100 + i));
    run(1'b1, 1'b1, 12'h030, 32'h999, 1'b1, 1'b0, 12'h034, 32'h0);
    chk("full_pop_rdata", d_rd, 32'd100);
    chk("full_pop_err", 32'(d_er), 32'h0);
    chk("full_push_err", 32'(h_er), 32'h1);
    dvc(1'b0, 12'h038, 32'h0);
    chk("fill7_status", d_rd, 32'h0000_0704);
    for (int i = 0; i < 4; i++) dvc(1'b0, 12'h034, 32'h0);
    run(1'b1, 1'b1, 12'h030, 32'h555, 1'b1, 1'b0, 12'h034, 32'h0);
    chk("mid_pop_rdata", d_rd, 32'd105);
    chk("mid_push_err", 32'(h_er), 32'h0);
    dvc(1'b0, 12'h038, 32'h0);
    chk("fill3_status", d_rd, 32'h0000_0304);
    for (int i = 0; i < 3; i++) dvc(1'b0, 12'h034, 32'h0);
    chk("drain_last", d_rd, 32'h555);

    // Reset mid-transaction discards queue, config and pending response
    for (int i = 0; i < 4; i++) hst(1'b1, 12'h000, 32'(i));
    dvc(1'b1, 12'h00C, 32'h0000_0101);
    idle();
    chk("pre_rst_irq", 32'(d_iq), 32'h1);
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 12'h000; host_wdata_i = 32'h4;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk("rst_drops_rvalid", 32'(host_rvalid_o), 32'h0);
    chk("rst_drops_irq", 32'(dev_irq_o), 32'h0);
    do_reset();
    hst(1'b0, 12'h008, 32'h0);
    chk("post_rst_host_status", h_rd, 32'h0000_0005);
    dvc(1'b0, 12'h008, 32'h0);
    chk("post_rst_dev_status", d_rd, 32'h0000_0005);
    dvc(1'b0, 12'h00C, 32'h0);
    chk("post_rst_irqcfg", d_rd, 32'h0);
    chk("post_rst_irq", 32'(d_iq), 32'h0);

    // Randomized concurrent traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rand_op(hr, hw, ha, hd);
      rand_op(dr, dw, da, dd);
      run(hr, hw, ha, hd, dr, dw, da, dd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hero_mbox_multi.md
HERO_MBOX_MULTI -- requirements
Module: hero_mbox_multi

Interface
REQ-001 NumChannels, 4, independent bidirectional channels; SHALL be 1..16.
REQ-002 Depth, 8, entries per FIFO per direction; SHALL be 1..255.
REQ-003 DataWidth, 32, message width; SHALL be 32 or 64.
REQ-004 AddrWidth, 12, byte-offset width; SHALL be >= log2(NumChannels*16).
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 host_req_i / dev_req_i  in  1  access request.
REQ-008 host_we_i / dev_we_i  in  1  1 = write, 0 = read.
REQ-009 host_addr_i / dev_addr_i  in  AddrWidth  byte offset within the mailbox.
REQ-010 host_wdata_i / dev_wdata_i  in  DataWidth  write data.
REQ-011 host_gnt_o / dev_gnt_o  out  1  grant; SHALL equal the corresponding req_i combinationally.
REQ-012 host_rvalid_o / dev_rvalid_o  out  1  response valid, one cycle after each grant (reads and writes).
REQ-013 host_rdata_o / dev_rdata_o  out  DataWidth  read data, valid with rvalid; 0 for writes and errors.
REQ-014 host_err_o / dev_err_o  out  1  error flag, valid with rvalid.
REQ-015 host_irq_o / dev_irq_o  out  1  level interrupt, active-high, registered.

Function
REQ-016 Per channel c: FIFO H2D (pushed by host, popped by dev) and FIFO D2H (pushed by dev, popped by host); each side sees its own "outbound" and "inbound" FIFO.
REQ-017 Register map per side at c*0x10: 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R), 0xC IRQCFG (R/W).
REQ-018 TXDATA write pushes wdata into outbound FIFO; if full: no push, err=1.
REQ-019 RXDATA read pops inbound FIFO, returns head; if empty: no pop, rdata=0, err=1.
REQ-020 STATUS: [0] inbound empty, [1] inbound full, [2] outbound empty, [3] outbound full, [15:8] inbound fill level, [23:16] outbound fill level, others 0; values as of the grant cycle.
REQ-021 IRQCFG: [0] enable, [15:8] threshold; per side, per channel, independent; other bits write-ignored, read 0.
REQ-022 Write to RXDATA/STATUS, read of TXDATA, addr[1:0]!=0, or channel index >= NumChannels: no state change, rdata=0, err=1.
REQ-023 Channel irq term = enable AND threshold != 0 AND inbound fill >= threshold; side irq = OR over channels, registered (one cycle after fill/config change).
REQ-024 Host push and dev pop on same FIFO in same cycle: both succeed if legal; fill level unchanged; if full, pop succeeds and push fails (full judged before the edge); if empty, pop fails and push succeeds.
REQ-025 FIFO pointers wrap modulo Depth; fill level SHALL range 0..Depth with no aliasing at full.
REQ-026 Data order per FIFO SHALL be strict FIFO; no cross-channel interaction.
REQ-027 Host and dev accesses are processed concurrently, no arbitration, no back-pressure.

Reset
REQ-028 While rst_i=1: all FIFOs empty, all IRQCFG = 0, rvalid/err/irq = 0, rdata = 0.
REQ-029 Reset asserted mid-transaction SHALL discard the pending response and all queued messages; first access after deassertion is serviced normally.

Verification
REQ-030 Host writes 0xA5A5_0001 to ch0 TXDATA; dev reads ch0 RXDATA -> rdata 0xA5A5_0001, err 0; dev STATUS[0]=1.
REQ-031 Depth=8: host pushes 9 words to ch2 -> 9th err=1; dev STATUS[15:8]=8, [1]=1; 8 dev pops return words 1..8 in order, 9th pop err=1, rdata 0.
REQ-032 Dev IRQCFG ch1 = 0x0301; host pushes 3 words -> dev_irq_o rises one cycle after 3rd push; dev pops one -> irq falls one cycle later; host_irq_o stays 0.
REQ-033 FIFO full; same-cycle host push and dev pop -> pop returns oldest, push err=1, fill 7; FIFO at fill 3 same cycle -> both succeed, fill stays 3.
REQ-034 Read TXDATA, write STATUS, addr 0x002, addr NumChannels*0x10 -> err=1, rdata 0, no FIFO/cfg change.
REQ-035 Push 5 words, set IRQCFG, pulse rst_i for 1 cycle -> all STATUS show empty, IRQCFG reads 0, irq 0.
